// File: rtl/mips_timer.sv
// Memory-mapped prescaled up-counter for the single-cycle datapath: programmable
// period, one-shot or periodic mode, and a sticky overflow flag.
module mips_timer #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      tmr_ctrl,
    output logic [CNT_W-1:0] tmr_cntr,
    output logic             tmr_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PSC_W-1:0] psc, psc_nxt;
    logic [CNT_W-1:0] cntr_nxt;
    logic             ovf_nxt;

    logic             en, mode, clr, tick, at_top;
    logic [PSC_W-1:0] presc;
    logic [CNT_W-1:0] top;
    logic             ctrl_unused;

    assign en          = tmr_ctrl[0];
    assign mode        = tmr_ctrl[1];
    assign clr         = tmr_ctrl[2];
    assign presc       = tmr_ctrl[8 +: PSC_W];
    assign top         = tmr_ctrl[16 +: CNT_W];
    assign ctrl_unused = ^tmr_ctrl[7:3];

    // >= rather than == so a TOP lowered below the live count still overflows
    assign tick   = (psc >= presc);
    assign at_top = (tmr_cntr >= top);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (en) state_nxt = RUN;
                RUN: begin
                    if (!en)
                        state_nxt = IDLE;
                    else if (tick && at_top && !mode)
                        state_nxt = DONE;
                end
                DONE: if (!en) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cntr_nxt = tmr_cntr;
        psc_nxt  = psc;
        ovf_nxt  = tmr_overflow;
        if (clr) begin
            cntr_nxt = '0;
            psc_nxt  = '0;
            ovf_nxt  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!en) begin
                        psc_nxt = '0;
                    end else if (tick) begin
                        psc_nxt = '0;
                        if (at_top) begin
                            cntr_nxt = '0;
                            ovf_nxt  = 1'b1;
                        end else begin
                            cntr_nxt = tmr_cntr + 1'b1;
                        end
                    end else begin
                        psc_nxt = psc + 1'b1;
                    end
                end
                default: psc_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_cntr     <= '0;
            psc          <= '0;
            tmr_overflow <= 1'b0;
        end else begin
            tmr_cntr     <= cntr_nxt;
            psc          <= psc_nxt;
            tmr_overflow <= ovf_nxt;
        end
    end

endmodule
